// File: rtl/seq_det_pkg.sv
// ============================================================================
// seq_det_pkg : shared types and helpers for the serial pattern detector
// Rev 1.0
// ============================================================================
`default_nettype none

package seq_det_pkg;

  localparam int MAX_PAT_W = 32;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Compares only the low 'len' bits; bits above len-1 are don't-care.
  function automatic logic masked_match(input logic [MAX_PAT_W-1:0] history,
                                        input logic [MAX_PAT_W-1:0] pattern,
                                        input int unsigned          len);
    logic hit;
    hit = 1'b1;
    for (int unsigned i = 0; i < MAX_PAT_W; i++) begin
      if ((i < len) && (history[i] != pattern[i])) hit = 1'b0;
    end
    return hit;
  endfunction

  function automatic int unsigned clamp_len(input int unsigned req,
                                            input int unsigned max_len);
    return (req > max_len) ? max_len : req;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// sat_counter : saturating event counter with sticky saturation flag
// Rev 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] MAX_CNT = '1;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clr) begin
      // A coincident event survives the clear as the first new count.
      count <= inc ? CNT_W'(1) : '0;
      sat   <= 1'b0;
    end else if (inc && (count != MAX_CNT)) begin
      count <= count + 1'b1;
      if ((count + 1'b1) == MAX_CNT) sat <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_pattern_detector.sv
// ============================================================================
// seq_pattern_detector : run-time loadable serial bit-pattern detector with
// overlap mode, qualified input strobe and saturating match counter
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             w_valid,
  input  logic             w,
  input  logic             clr_count,
  output logic             p,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat,
  output logic             armed
);

  localparam logic [LEN_W-1:0] FULL = LEN_W'(PAT_W);

  state_t           state, state_n;
  logic [PAT_W-1:0] history, history_n, pattern;
  logic [LEN_W-1:0] fill, fill_n, len, len_req;
  logic             overlap, accept, match;

  assign len_req   = LEN_W'(clamp_len(32'(cfg_len), PAT_W));
  // A load in the same cycle wins over the sample, which is dropped.
  assign accept    = (state == ST_RUN) && w_valid && !cfg_load;
  assign history_n = {history[PAT_W-2:0], w};
  assign fill_n    = (fill == FULL) ? fill : fill + 1'b1;
  assign match     = accept && (fill_n >= len) &&
                     masked_match(MAX_PAT_W'(history_n), MAX_PAT_W'(pattern), 32'(len));

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= ST_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (cfg_load) state_n = (cfg_len == '0) ? ST_IDLE : ST_RUN;
  end

  always_comb begin
    armed = (state == ST_RUN);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pattern <= '0;
      len     <= '0;
      overlap <= 1'b0;
    end else if (cfg_load) begin
      pattern <= cfg_pattern;
      len     <= len_req;
      overlap <= cfg_overlap;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      history <= '0;
      fill    <= '0;
      p       <= 1'b0;
    end else begin
      p <= match;
      if (cfg_load) begin
        history <= '0;
        fill    <= '0;
      end else if (accept) begin
        history <= history_n;
        // Non-overlapping mode demands len fresh bits after each hit.
        fill    <= (match && !overlap) ? '0 : fill_n;
      end
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_match_cnt (
    .Clock (Clock),
    .Resetn(Resetn),
    .clr   (clr_count),
    .inc   (match),
    .count (match_count),
    .sat   (count_sat)
  );

endmodule

`default_nettype wire

// File: tb/tb_seq_pattern_detector.sv
// ============================================================================
// tb_seq_pattern_detector : directed self-checking bench for the detector
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_seq_pattern_detector;

  localparam int PAT_W = 8;
  localparam int CNT_W = 2;
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             Clock = 1'b0;
  logic             Resetn = 1'b0;
  logic             cfg_load = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_overlap = 1'b0;
  logic             w_valid = 1'b0;
  logic             w = 1'b0;
  logic             clr_count = 1'b0;
  logic             p;
  logic [CNT_W-1:0] match_count;
  logic             count_sat;
  logic             armed;

  int compared = 0;
  int mismatched = 0;

  seq_pattern_detector #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .w_valid    (w_valid),
    .w          (w),
    .clr_count  (clr_count),
    .p          (p),
    .match_count(match_count),
    .count_sat  (count_sat),
    .armed      (armed)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic load(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len, input logic ov);
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ov; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic clr();
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
  endtask

  // Send one bit (or a bubble when v=0) and check p on the following cycle.
  task automatic send(input string tag, input logic b, input logic v, input logic exp_p);
    w = b; w_valid = v;
    tick();
    w_valid = 1'b0;
    chk(tag, 32'(p), 32'(exp_p));
  endtask

  initial begin
    #12;
    chk("rst_p", 32'(p), 0);
    chk("rst_cnt", 32'(match_count), 0);
    chk("rst_sat", 32'(count_sat), 0);
    chk("rst_armed", 32'(armed), 0);
    tick();
    Resetn = 1'b1;
    tick();
    send("idle_ignore", 1'b1, 1'b1, 1'b0);

    // overlapping 101
    load(8'b101, 4'd3, 1'b1);
    chk("ov_armed", 32'(armed), 1);
    send("ov_b1", 1, 1, 0);
    send("ov_b2", 0, 1, 0);
    send("ov_b3", 1, 1, 1);
    send("ov_b4", 0, 1, 0);
    send("ov_b5", 1, 1, 1);
    chk("ov_cnt", 32'(match_count), 2);
    clr();
    chk("clr_cnt", 32'(match_count), 0);

    // non-overlapping 101
    load(8'b101, 4'd3, 1'b0);
    send("nov_b1", 1, 1, 0);
    send("nov_b2", 0, 1, 0);
    send("nov_b3", 1, 1, 1);
    send("nov_b4", 0, 1, 0);
    send("nov_b5", 1, 1, 0);
    send("nov_b6", 1, 1, 0);
    send("nov_b7", 0, 1, 0);
    send("nov_b8", 1, 1, 1);
    chk("nov_cnt", 32'(match_count), 2);
    clr();

    // bubbles between bits
    load(8'b101, 4'd3, 1'b1);
    send("bub_b1", 1, 1, 0);
    send("bub_g1", 0, 0, 0);
    send("bub_b2", 0, 1, 0);
    send("bub_g2", 1, 0, 0);
    send("bub_g3", 1, 0, 0);
    send("bub_b3", 1, 1, 1);
    send("bub_g4", 1, 0, 0);
    chk("bub_cnt", 32'(match_count), 1);
    clr();

    // saturation with a 2-bit counter
    load(8'b1, 4'd1, 1'b1);
    send("sat_p1", 1, 1, 1);
    chk("sat_c1", 32'(match_count), 1);
    chk("sat_s1", 32'(count_sat), 0);
    send("sat_p2", 1, 1, 1);
    chk("sat_c2", 32'(match_count), 2);
    chk("sat_s2", 32'(count_sat), 0);
    send("sat_p3", 1, 1, 1);
    chk("sat_c3", 32'(match_count), 3);
    chk("sat_s3", 32'(count_sat), 1);
    send("sat_p4", 1, 1, 1);
    chk("sat_c4", 32'(match_count), 3);
    send("sat_p5", 1, 1, 1);
    chk("sat_c5", 32'(match_count), 3);
    chk("sat_s5", 32'(count_sat), 1);
    clr();
    chk("sat_clr_c", 32'(match_count), 0);
    chk("sat_clr_s", 32'(count_sat), 0);
    clr_count = 1'b1;
    send("clrhit_p", 1, 1, 1);
    clr_count = 1'b0;
    chk("clrhit_c", 32'(match_count), 1);
    chk("clrhit_s", 32'(count_sat), 0);
    clr();

    // full-length pattern A5 = 1010_0101, oldest bit first
    load(8'hA5, 4'd8, 1'b0);
    send("a5_b1", 1, 1, 0);
    send("a5_b2", 0, 1, 0);
    send("a5_b3", 1, 1, 0);
    send("a5_b4", 0, 1, 0);
    send("a5_b5", 0, 1, 0);
    send("a5_b6", 1, 1, 0);
    send("a5_b7", 0, 1, 0);
    send("a5_b8", 1, 1, 1);
    chk("a5_cnt", 32'(match_count), 1);
    clr();

    // cfg_load coincident with a valid sample: sample dropped
    cfg_pattern = 8'b11; cfg_len = 4'd2; cfg_overlap = 1'b1;
    cfg_load = 1'b1; w = 1'b1; w_valid = 1'b1;
    tick();
    cfg_load = 1'b0; w_valid = 1'b0;
    chk("ldv_p", 32'(p), 0);
    send("ldv_b1", 1, 1, 0);
    send("ldv_b2", 1, 1, 1);
    chk("ldv_cnt", 32'(match_count), 1);

    // zero length disarms
    load(8'b1, 4'd0, 1'b1);
    chk("len0_armed", 32'(armed), 0);
    send("len0_b1", 1, 1, 0);
    send("len0_b2", 1, 1, 0);

    // asynchronous reset mid-stream
    load(8'b101, 4'd3, 1'b1);
    chk("mid_armed", 32'(armed), 1);
    send("mid_b1", 1, 1, 0);
    send("mid_b2", 0, 1, 0);
    #2;
    Resetn = 1'b0;
    #1;
    chk("mid_rst_p", 32'(p), 0);
    chk("mid_rst_cnt", 32'(match_count), 0);
    chk("mid_rst_armed", 32'(armed), 0);
    #3;
    Resetn = 1'b1;
    send("post_b1", 1, 1, 0);
    send("post_b2", 0, 1, 0);
    send("post_b3", 1, 1, 0);
    chk("post_armed", 32'(armed), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_pattern_detector.md
# seq_pattern_detector

Parametrised serial bit-pattern detector, the successor to the fixed six-state sequence-detector FSM. It replaces a hard-coded state graph with a run-time loadable pattern of up to PAT_W bits and a selectable overlapping or non-overlapping match mode. It adds a qualified input strobe, a saturating match counter and a registered one-cycle match pulse. It sits on a serial bit stream and flags every occurrence of the loaded pattern.

## Interface
- PAT_W, 8, maximum pattern length in bits (≥2).
- CNT_W, 8, match counter width (≥1).
- LEN_W, $clog2(PAT_W+1), width of the length field (derived; do not override).

Ports:
- Clock  in  1  rising-edge system clock.
- Resetn  in  1  reset, asynchronous, active-low.
- cfg_load  in  1  one-cycle strobe that latches cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  in  PAT_W  pattern bits; bit [len-1] is the first/oldest bit received, bit [0] is the last.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping matches allowed; 0 = history restarts after each match.
- w_valid  in  1  input bit qualifier.
- w  in  1  serial data bit, sampled only when w_valid=1.
- clr_count  in  1  synchronous clear of match_count and count_sat.
- p  out  1  registered match pulse.
- match_count  out  CNT_W  number of matches since reset or clear.
- count_sat  out  1  sticky; set when match_count saturates.
- armed  out  1  1 while in RUN.

## Operation
- States: IDLE and RUN.
- Reset values: state IDLE, history 0, fill 0, p 0, match_count 0, count_sat 0, armed 0. All registers reset asynchronously.
- IDLE: samples are ignored and p stays 0.
- cfg_load (either state):
  - Latch the pattern, the length and the overlap mode.
  - Clear history and fill.
  - If cfg_len=0, go to IDLE. Otherwise go to RUN with len = min(cfg_len, PAT_W).
  - match_count is not affected.
- cfg_load has priority over w_valid in the same cycle; that sample is dropped.
- RUN, when w_valid=1:
  - history_n = {history[PAT_W-2:0], w}.
  - fill_n = min(fill+1, PAT_W).
  - match = (fill_n ≥ len) && (history_n[len-1:0] == pattern[len-1:0]).
- On match:
  - p is set to 1 on the next edge.
  - match_count increments, saturating at 2^CNT_W-1.
  - count_sat is set on the increment that reaches the all-ones value.
  - If cfg_overlap=0, fill is cleared instead of taking fill_n, so the next match needs len fresh bits.
- RUN, when w_valid=0: history and fill hold, and p is 0 on the next edge.
- clr_count: match_count and count_sat go to 0.
  - clr_count together with a match in the same cycle gives match_count=1 and count_sat=0.
- Bits not covered by len (pattern bits above len-1) are don't-care.

## Timing
- p is registered. It is high for exactly one cycle, the cycle after the edge that accepts the completing bit (latency 1).
- Back-to-back matches give a continuous high p, one cycle per match.
- match_count and count_sat update on the same edge that sets p.
- armed updates on the edge that accepts cfg_load.
- Resetn asserted mid-operation: all outputs go to their reset values immediately, without waiting for a clock edge.
  - After Resetn deasserts, the block stays in IDLE until a cfg_load arrives.
- Bubbles (w_valid=0) between bits do not break a partial match.

## Structure
- Package seq_det_pkg holds:
  - the state enum (ST_IDLE, ST_RUN);
  - a masked-compare function taking (history, pattern, len);
  - a len clamp function.
- Sub-module sat_counter (parameter CNT_W) contains the inc, clr and sat logic. It is instantiated once for match_count and count_sat.
- The FSM, history shifter and fill counter live in the top module.

## Test plan
- Overlap mode, pattern 3'b101, len 3, overlap=1. Feed 1,0,1,0,1 with w_valid=1 each cycle -> p high the cycle after bit 3 and after bit 5, match_count=2.
- Same pattern with overlap=0. Feed 1,0,1,0,1,1,0,1 -> p only after bits 3 and 8, match_count=2.
- Bubbles: feed 1,0,1 with one or two w_valid=0 cycles between bits -> a single p pulse, and p stays 0 during the bubbles.
- Saturation with CNT_W=2 and pattern 1'b1, len 1. Feed 5 ones -> match_count 1,2,3,3,3 and count_sat=1 from the third match. Then pulse clr_count -> 0/0; assert clr_count with a match in the same cycle -> match_count=1.
- Configuration:
  - Full-length pattern 8'hA5, len 8 -> match only after 8 correct bits.
  - cfg_load with w_valid=1 in the same cycle -> that sample is dropped and fill restarts.
  - cfg_len=0 -> armed=0 and no further p.
- Reset mid-stream: drop Resetn between clock edges after two of three pattern bits -> p, match_count and armed go to 0 immediately. After release, w_valid bits produce no p until a cfg_load.
